// File: rtl/regfile_2w2r_if.sv
// rtl/regfile_2w2r_if.sv - Decode/ALU-side signal bundle for the 2-write 2-read register file
interface regfile_2w2r_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ready;
    logic              rd_en;
    logic [ADDR_W-1:0] register1;
    logic [ADDR_W-1:0] register2;
    logic [DATA_W-1:0] immediate;
    logic              ALUSrc;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              RegWrite0;
    logic [ADDR_W-1:0] writeRegister0;
    logic [DATA_W-1:0] writeData0;
    logic              RegWrite1;
    logic [ADDR_W-1:0] writeRegister1;
    logic [DATA_W-1:0] writeData1;
    logic              wr_conflict;

    modport master (
        input  ready, data1, data2, wr_conflict,
        output rd_en, register1, register2, immediate, ALUSrc,
               RegWrite0, writeRegister0, writeData0,
               RegWrite1, writeRegister1, writeData1
    );

    modport slave (
        output ready, data1, data2, wr_conflict,
        input  rd_en, register1, register2, immediate, ALUSrc,
               RegWrite0, writeRegister0, writeData0,
               RegWrite1, writeRegister1, writeData1
    );
endinterface

// File: rtl/regfile_2w2r.sv
// rtl/regfile_2w2r.sv - 2-write 2-read register file with registered reads, bypass and post-reset clear sweep
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic           clk,
    input  logic           reset,
    regfile_2w2r_if.slave  rf
);
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic              wr_conflict_q, wr_conflict_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              clr_we;
    logic              we0, we1;
    logic [DATA_W-1:0] rd1_val, rd2_val;

    always_comb begin
        run = (state_q == ST_RUN);
        we0 = run && rf.RegWrite0 && (rf.writeRegister0 != ZERO_ADDR);
        we1 = run && rf.RegWrite1 && (rf.writeRegister1 != ZERO_ADDR);

        // Port 1 wins over port 0 on the bypass path, matching array priority
        rd1_val = mem[rf.register1];
        if (rf.register1 == ZERO_ADDR)                       rd1_val = '0;
        else if (we1 && rf.writeRegister1 == rf.register1)   rd1_val = rf.writeData1;
        else if (we0 && rf.writeRegister0 == rf.register1)   rd1_val = rf.writeData0;

        rd2_val = mem[rf.register2];
        if (rf.register2 == ZERO_ADDR)                       rd2_val = '0;
        else if (we1 && rf.writeRegister1 == rf.register2)   rd2_val = rf.writeData1;
        else if (we0 && rf.writeRegister0 == rf.register2)   rd2_val = rf.writeData0;
    end

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        clr_we        = 1'b0;
        data1_d       = data1_q;
        data2_d       = data2_q;
        wr_conflict_d = we0 && we1 && (rf.writeRegister0 == rf.writeRegister1);

        case (state_q)
            ST_INIT: begin
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (rf.rd_en) begin
                    data1_d = rd1_val;
                    data2_d = rf.ALUSrc ? rf.immediate : rd2_val;
                end
            end
            default: state_d = ST_INIT;
        endcase

        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            clr_idx_q     <= '0;
            ready_q       <= 1'b0;
            data1_q       <= '0;
            data2_q       <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            ready_q       <= ready_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Array carries no reset so it can map to RAM; the sweep clears it instead
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) mem[clr_idx_q]         <= '0;
            if (we0)    mem[rf.writeRegister0] <= rf.writeData0;
            if (we1)    mem[rf.writeRegister1] <= rf.writeData1;
        end
    end

    assign rf.ready       = ready_q;
    assign rf.data1       = data1_q;
    assign rf.data2       = data2_q;
    assign rf.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_2w2r.sv
// tb/tb_regfile_2w2r.sv - Directed-vector bench for regfile_2w2r
module tb_regfile_2w2r;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   n;

    regfile_2w2r_if #(.DATA_W(32), .ADDR_W(5)) rf ();

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rf.rd_en          = 1'b0;
        rf.register1      = '0;
        rf.register2      = '0;
        rf.immediate      = '0;
        rf.ALUSrc         = 1'b0;
        rf.RegWrite0      = 1'b0;
        rf.writeRegister0 = '0;
        rf.writeData0     = '0;
        rf.RegWrite1      = 1'b0;
        rf.writeRegister1 = '0;
        rf.writeData1     = '0;
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (!rf.ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd32);
    endtask

    task automatic read_regs(input logic [4:0] a1, input logic [4:0] a2);
        rf.rd_en     = 1'b1;
        rf.register1 = a1;
        rf.register2 = a2;
        tick();
        rf.rd_en     = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        check("rst_ready", 32'(rf.ready), 32'd0);
        check("rst_data1", rf.data1, 32'd0);
        check("rst_data2", rf.data2, 32'd0);
        check("rst_wrc",   32'(rf.wr_conflict), 32'd0);
        reset = 1'b0;
        wait_ready("sweep_len");

        for (int a = 0; a < 32; a++) begin
            read_regs(5'(a), 5'(31 - a));
            check($sformatf("clr_d1_r%0d", a), rf.data1, 32'd0);
            check($sformatf("clr_d2_r%0d", 31 - a), rf.data2, 32'd0);
        end

        // Same-cycle write -> read bypass
        rf.RegWrite0 = 1'b1; rf.writeRegister0 = 5'd5; rf.writeData0 = 32'hDEADBEEF;
        rf.rd_en = 1'b1; rf.register1 = 5'd5; rf.register2 = 5'd0;
        tick();
        rf.RegWrite0 = 1'b0;
        check("bypass_r5", rf.data1, 32'hDEADBEEF);
        read_regs(5'd5, 5'd5);
        check("mem_r5_d1", rf.data1, 32'hDEADBEEF);
        check("mem_r5_d2", rf.data2, 32'hDEADBEEF);

        // Zero register: write dropped, no bypass
        rf.RegWrite0 = 1'b1; rf.writeRegister0 = 5'd0; rf.writeData0 = 32'h1234;
        rf.rd_en = 1'b1; rf.register1 = 5'd0;
        tick();
        rf.RegWrite0 = 1'b0;
        check("zero_bypass", rf.data1, 32'd0);
        read_regs(5'd0, 5'd0);
        check("zero_read", rf.data1, 32'd0);

        // Both ports to r7: port 1 wins, conflict pulse
        rf.RegWrite0 = 1'b1; rf.writeRegister0 = 5'd7; rf.writeData0 = 32'h1111;
        rf.RegWrite1 = 1'b1; rf.writeRegister1 = 5'd7; rf.writeData1 = 32'h2222;
        rf.rd_en = 1'b1; rf.register1 = 5'd7; rf.register2 = 5'd5;
        tick();
        rf.RegWrite0 = 1'b0; rf.RegWrite1 = 1'b0;
        check("conf_pulse",  32'(rf.wr_conflict), 32'd1);
        check("conf_bypass", rf.data1, 32'h2222);
        read_regs(5'd7, 5'd7);
        check("conf_clear", 32'(rf.wr_conflict), 32'd0);
        check("conf_r7",    rf.data1, 32'h2222);

        // Both ports to r0: dropped, no conflict
        rf.RegWrite0 = 1'b1; rf.writeRegister0 = 5'd0; rf.writeData0 = 32'h3333;
        rf.RegWrite1 = 1'b1; rf.writeRegister1 = 5'd0; rf.writeData1 = 32'h4444;
        tick();
        rf.RegWrite0 = 1'b0; rf.RegWrite1 = 1'b0;
        check("conf_zero", 32'(rf.wr_conflict), 32'd0);

        // Distinct addresses on the two write ports
        rf.RegWrite0 = 1'b1; rf.writeRegister0 = 5'd6; rf.writeData0 = 32'h0600_0006;
        rf.RegWrite1 = 1'b1; rf.writeRegister1 = 5'd8; rf.writeData1 = 32'h0800_0008;
        tick();
        rf.RegWrite0 = 1'b0; rf.RegWrite1 = 1'b0;
        check("dual_nocnf", 32'(rf.wr_conflict), 32'd0);
        read_regs(5'd6, 5'd8);
        check("dual_r6", rf.data1, 32'h0600_0006);
        check("dual_r8", rf.data2, 32'h0800_0008);

        // rd_en low holds outputs
        rf.rd_en = 1'b0; rf.register1 = 5'd5; rf.register2 = 5'd7;
        tick();
        check("hold_d1", rf.data1, 32'h0600_0006);
        check("hold_d2", rf.data2, 32'h0800_0008);

        // ALUSrc immediate mux
        rf.ALUSrc = 1'b1; rf.immediate = 32'hFFFF_FFF0;
        read_regs(5'd5, 5'd7);
        check("imm_d2", rf.data2, 32'hFFFF_FFF0);
        check("imm_d1", rf.data1, 32'hDEADBEEF);
        rf.ALUSrc = 1'b0;
        read_regs(5'd5, 5'd7);
        check("reg_d2", rf.data2, 32'h2222);

        // Reset mid-RUN, then again mid-sweep
        rf.RegWrite0 = 1'b1; rf.writeRegister0 = 5'd9; rf.writeData0 = 32'hAA;
        tick();
        rf.RegWrite0 = 1'b0;
        reset = 1'b1;
        tick();
        check("rst2_ready", 32'(rf.ready), 32'd0);
        check("rst2_data1", rf.data1, 32'd0);
        check("rst2_data2", rf.data2, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_ready", 32'(rf.ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rf.RegWrite0 = 1'b1; rf.writeRegister0 = 5'd3; rf.writeData0 = 32'h55;
        rf.RegWrite1 = 1'b1; rf.writeRegister1 = 5'd4; rf.writeData1 = 32'h66;
        rf.rd_en = 1'b1; rf.register1 = 5'd3; rf.register2 = 5'd4;
        wait_ready("sweep_len2");
        rf.RegWrite0 = 1'b0; rf.RegWrite1 = 1'b0; rf.rd_en = 1'b0;
        check("init_d1", rf.data1, 32'd0);
        check("init_wrc", 32'(rf.wr_conflict), 32'd0);
        read_regs(5'd9, 5'd3);
        check("post_r9", rf.data1, 32'd0);
        check("post_r3", rf.data2, 32'd0);
        read_regs(5'd4, 5'd5);
        check("post_r4", rf.data1, 32'd0);
        check("post_r5", rf.data2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
